fifo_uart_tx: RTL and testbench

Serial transmit stage that drains bytes from the board FIFO and sends them as 8N1 UART frames on a single output pin. It sits directly downstream of the FIFO: it watches `fifo_empty`, issues one-cycle read pulses, captures the byte presented on the FIFO read port, and serialises it LSB-first at a fixed baud rate.

---
 rtl/fifo_uart_pkg.sv | 22 ++
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/fifo_uart_tx.sv | 142 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// Optional even-parity bit is enabled by defining FIFO_UART_TX_PARITY_EN.
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPop,
      StWait,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   localparam logic TX_IDLE = 1'b1;

   function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq_hz,
                                                     input int unsigned baud);
      return clk_freq_hz / baud;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: bit_end is high on the last cycle of each bit period.
// Holding clear restarts the period from zero.
module uart_baud_cnt #(
   parameter int unsigned CLKS_PER_BIT = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   assign bit_end = (cnt_q == CntLast);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a FIFO and sends them LSB-first as 8N1 (or 8E1 when
// FIFO_UART_TX_PARITY_EN is defined) UART frames. All outputs are registered.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned BAUD        = 9600
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);
   localparam int unsigned IdxW = $clog2(DATA_WIDTH);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

   state_e                state_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [IdxW-1:0]       idx_q;
   logic                  tx_q;
   logic                  busy_q;
   logic                  rd_en_q;
   logic                  done_q;
   logic                  cnt_clear;
   logic                  bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
   logic                  parity_q;
`endif

   // The counter only runs in the timed states, so it is always at zero on entry to START.
   assign cnt_clear = (state_q == StIdle) || (state_q == StPop) || (state_q == StWait);

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .bit_end(bit_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= TX_IDLE;
         busy_q  <= 1'b0;
         rd_en_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         rd_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (!fifo_empty) begin
                  state_q <= StPop;
                  rd_en_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            StPop: begin
               state_q <= StWait;
            end
            StWait: begin
               shift_q <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
               parity_q <= ^fifo_data;
`endif
               tx_q    <= 1'b0;
               state_q <= StStart;
            end
            StStart: begin
               if (bit_end) begin
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  idx_q   <= '0;
                  state_q <= StData;
               end
            end
            StData: begin
               if (bit_end) begin
                  if (idx_q == IdxLast) begin
`ifdef FIFO_UART_TX_PARITY_EN
                     tx_q    <= parity_q;
                     state_q <= StParity;
`else
                     tx_q    <= TX_IDLE;
                     state_q <= StStop;
`endif
                  end else begin
                     tx_q    <= shift_q[0];
                     shift_q <= shift_q >> 1;
                     idx_q   <= idx_q + IdxW'(1);
                  end
               end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            StParity: begin
               if (bit_end) begin
                  tx_q    <= TX_IDLE;
                  state_q <= StStop;
               end
            end
`endif
            StStop: begin
               if (bit_end) begin
                  done_q <= 1'b1;
                  if (!fifo_empty) begin
                     state_q <= StPop;
                     rd_en_q <= 1'b1;
                  end else begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               tx_q    <= TX_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_rd_en = rd_en_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with CLKS_PER_BIT = 10; expected line levels
// come from a per-slot frame model. Define FIFO_UART_TX_PARITY_EN to check 8E1 frames.
module tb_fifo_uart_tx;

   localparam int unsigned DW     = 8;
   localparam int unsigned CLK_HZ = 100;
   localparam int unsigned BAUD_R = 10;
   localparam int unsigned C      = CLK_HZ / BAUD_R;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int unsigned NSLOT = DW + 3;
`else
   localparam int unsigned NSLOT = DW + 2;
`endif
   localparam int unsigned FRAME = NSLOT * C;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd_en;
   logic          tx;
   logic          busy;
   logic          frame_done;

   logic [7:0] fq[$];
   logic [7:0] burst[$];
   logic       toggle_mode = 1'b0;
   logic       tog = 1'b0;
   int         cyc = 0;
   int         rd_cnt = 0;
   int         rd_last = -1000;
   int         underflow = 0;
   int         vectors = 0;
   int         miscompares = 0;

   fifo_uart_tx #(
      .DATA_WIDTH (DW),
      .CLK_FREQ_HZ(CLK_HZ),
      .BAUD       (BAUD_R)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fifo_data (fifo_data),
      .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en),
      .tx        (tx),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // FIFO model: read data appears one cycle after the read strobe.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      tog <= ~tog;
      if (fifo_rd_en) begin
         if (fq.size() > 0) fifo_data <= fq.pop_front();
         else underflow <= underflow + 1;
      end
   end

   always begin
      @(negedge clk);
      #1;
      fifo_empty = (fq.size() == 0) || (toggle_mode && tog);
   end

   always @(negedge clk) begin
      if (fifo_rd_en) begin
         rd_cnt  = rd_cnt + 1;
         rd_last = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Line level for slot 0 (start), data slots, optional parity, then stop.
   function automatic logic exp_level(input logic [7:0] b, input int unsigned slot);
      if (slot == 0) return 1'b0;
      if (slot <= DW) return b[slot-1];
`ifdef FIFO_UART_TX_PARITY_EN
      if (slot == DW + 1) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic check_frame(input logic [7:0] b, input int unsigned upto,
                              output int waited, output int fall_cyc);
      int w;
      int rd_snap;
      w = 0;
      @(negedge clk);
      while (tx !== 1'b0 && w < 400) begin
         w++;
         @(negedge clk);
      end
      waited   = w;
      fall_cyc = cyc;
      rd_snap  = rd_cnt;
      chk("start_edge", tx, 0);
      chk("rd_to_fall", fall_cyc - rd_last, 2);
      for (int c = 0; c < int'(upto); c++) begin
         if (c > 0) @(negedge clk);
         chk("tx_level", tx, exp_level(b, c / C));
         chk("busy_in_frame", busy, 1);
         chk("no_done_mid", frame_done, 0);
      end
      chk("no_rd_in_frame", rd_cnt - rd_snap, 0);
      if (upto == FRAME) begin
         @(negedge clk);
         chk("frame_done", frame_done, 1);
      end
   endtask

   task automatic run_burst();
      int n, w, f, prev_f;
      n = burst.size();
      prev_f = 0;
      foreach (burst[i]) fq.push_back(burst[i]);
      for (int i = 0; i < n; i++) begin
         check_frame(burst[i], FRAME, w, f);
         if (i > 0) begin
            chk("frame_spacing", f - prev_f, FRAME + 2);
            chk("line_high_gap", C + 1 + w, C + 2);
         end
         prev_f = f;
      end
      chk("idle_busy", busy, 0);
      chk("idle_tx", tx, 1);
      burst.delete();
   endtask

   initial begin
      int w, f, snap, n;

      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_tx", tx, 1);
         chk("rst_busy", busy, 0);
         chk("rst_rd", fifo_rd_en, 0);
         chk("rst_done", frame_done, 0);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("empty_tx", tx, 1);
         chk("empty_busy", busy, 0);
         chk("empty_rd", fifo_rd_en, 0);
      end

      snap  = rd_cnt;
      burst = '{8'hA5};
      run_burst();
      chk("single_rd", rd_cnt - snap, 1);

      snap  = rd_cnt;
      burst = '{8'h00, 8'hFF};
      run_burst();
      chk("pair_rd", rd_cnt - snap, 2);

      burst = '{8'h07, 8'h03};
      run_burst();

      // Reset in the middle of data bit 3 (slot 4).
      fq.push_back(8'h3C);
      check_frame(8'h3C, 4 * C + C / 2, w, f);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_tx", tx, 1);
      chk("midrst_busy", busy, 0);
      rst  = 1'b0;
      snap = rd_cnt;
      repeat (20) begin
         @(negedge clk);
         chk("postrst_tx", tx, 1);
         chk("postrst_busy", busy, 0);
      end
      chk("postrst_no_rd", rd_cnt - snap, 0);
      burst = '{8'h81};
      run_burst();
      chk("postrst_one_rd", rd_cnt - snap, 1);

      // fifo_empty toggling while a frame is on the line.
      fq.push_back(8'h5A);
      fq.push_back(8'h12);
      toggle_mode = 1'b1;
      check_frame(8'h5A, FRAME, w, f);
      toggle_mode = 1'b0;
      check_frame(8'h12, FRAME, w, f);
      chk("toggle_idle", busy, 0);

      for (int r = 0; r < 5; r++) begin
         n = $urandom_range(1, 3);
         for (int j = 0; j < n; j++) burst.push_back(8'($urandom));
         run_burst();
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      chk("fifo_underflow", underflow, 0);
      chk("fifo_drained", fq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
